// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART block framer: state encoding, parity modes
// and the byte parity helper used by the receive checker and the transmitter.
package aes_uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_ACK   = 3'd1,
    RX_NEXT  = 3'd2,
    BLK_OUT  = 3'd3,
    RES_WAIT = 3'd4,
    TX_LOAD  = 3'd5,
    TX_START = 3'd6,
    TX_WAIT  = 3'd7
  } stateT;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

  // Bit that makes the byte plus parity carry an even number of ones.
  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/aes_block_serializer.sv
// Shifts a result block out to the UART transmitter one byte at a time,
// most-significant byte first, with even parity alongside each byte.
module aes_block_serializer
  import aes_uart_pkg::*;
#(
  parameter int BLOCK_BYTES = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [8*BLOCK_BYTES-1:0] blockIn,
  output logic                     done,
  input  logic                     tx_busy,
  output logic                     tx_begin,
  output logic [7:0]               tx_data,
  output logic                     tx_parity
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);

  stateT          state;
  logic [W-1:0]   shiftReg;
  logic [CW-1:0]  byteCnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shiftReg  <= '0;
      byteCnt   <= '0;
      done      <= 1'b0;
      tx_begin  <= 1'b0;
      tx_data   <= '0;
      tx_parity <= 1'b0;
    end else begin
      // NOTE: state is written with <= so every branch sees the values from the
      // start of the cycle; the pulse defaults below are overridden only where set.
      done     <= 1'b0;
      tx_begin <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shiftReg <= blockIn;
            byteCnt  <= '0;
            state    <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (!tx_busy) begin
            tx_data   <= shiftReg[W-1 -: 8];
            tx_parity <= evenParity(shiftReg[W-1 -: 8]);
            shiftReg  <= shiftReg << 8;
            tx_begin  <= 1'b1;
            state     <= TX_START;
          end
        end
        TX_START: state <= TX_WAIT;
        TX_WAIT: begin
          // The UART acknowledges a start by raising busy; only then move on.
          if (tx_busy) begin
            if (byteCnt == LAST_BYTE) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              byteCnt <= byteCnt + 1'b1;
              state   <= TX_LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aes_uart_framer.sv
// Assembles UART bytes (optionally with parity bytes) into a block for a core,
// then sends the core's result block back out through the UART transmitter.
module aes_uart_framer
  import aes_uart_pkg::*;
#(
  parameter int BLOCK_BYTES    = 16,
  parameter int PARITY_MODE    = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_rdy,
  input  logic [7:0]               rx_data,
  output logic                     rx_rdy_clr,
  input  logic                     tx_busy,
  output logic                     tx_begin,
  output logic [7:0]               tx_data,
  output logic                     tx_parity,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  input  logic [8*BLOCK_BYTES-1:0] res_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  output logic [BLOCK_BYTES-1:0]   par_err_mask,
  output logic [7:0]               err_count,
  output logic                     frame_timeout
);

  localparam int W     = 8 * BLOCK_BYTES;
  localparam int SLOTS = BLOCK_BYTES * ((PARITY_MODE == PARITY_EVEN) ? 2 : 1);
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LAST_SLOT      = SW'(SLOTS - 1);
  localparam bit            TIMEOUT_ON     = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]   TIMEOUT_LAST   = TIMEOUT_ON ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  stateT          state;
  logic [SW-1:0]  slot;
  logic [31:0]    idleCnt;
  logic [SW-1:0]  byteIdx;
  logic           paritySlot;
  logic [7:0]     curByte;
  logic           blkTaken;
  logic           serStart;
  logic           serDone;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    byteIdx    = (PARITY_MODE == PARITY_EVEN) ? (slot >> 1) : slot;
    paritySlot = (PARITY_MODE == PARITY_EVEN) && slot[0];
    curByte    = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (byteIdx == SW'(k)) curByte = blk_data[W-1-8*k -: 8];
    end
  end

  // blk_valid is already high in RX_NEXT for the last slot, so accept there too.
  assign blkTaken = blk_valid && blk_ready && (state == RX_NEXT || state == BLK_OUT);
  // Start coincides with the result handshake so res_data is latched on that edge.
  assign serStart = (state == RES_WAIT) && res_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      slot          <= '0;
      idleCnt       <= '0;
      rx_rdy_clr    <= 1'b0;
      // NOTE: the block register is an output that must read zero after reset,
      // so it is reset like ordinary state rather than treated as storage.
      blk_data      <= '0;
      blk_valid     <= 1'b0;
      res_ready     <= 1'b0;
      par_err_mask  <= '0;
      err_count     <= '0;
      frame_timeout <= 1'b0;
    end else begin
      rx_rdy_clr    <= 1'b0;
      frame_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            rx_rdy_clr <= 1'b1;
            idleCnt    <= '0;
            state      <= RX_ACK;
            for (int k = 0; k < BLOCK_BYTES; k++) begin
              if (byteIdx == SW'(k)) begin
                if (!paritySlot) blk_data[W-1-8*k -: 8] <= rx_data;
                else if (rx_data[0] != evenParity(curByte)) par_err_mask[k] <= 1'b1;
              end
            end
          end else if (TIMEOUT_ON && slot != '0) begin
            if (idleCnt == TIMEOUT_LAST) begin
              slot          <= '0;
              idleCnt       <= '0;
              blk_data      <= '0;
              par_err_mask  <= '0;
              frame_timeout <= 1'b1;
            end else begin
              idleCnt <= idleCnt + 32'd1;
            end
          end
        end
        RX_ACK: begin
          if (slot == LAST_SLOT) blk_valid <= 1'b1;
          state <= RX_NEXT;
        end
        RX_NEXT: begin
          if (slot == LAST_SLOT) begin
            state <= BLK_OUT;
          end else begin
            slot  <= slot + 1'b1;
            state <= IDLE;
          end
        end
        BLK_OUT: ;
        RES_WAIT: begin
          if (res_valid) begin
            res_ready <= 1'b0;
            state     <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (serDone) begin
            slot    <= '0;
            idleCnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (blkTaken) begin
        blk_valid    <= 1'b0;
        res_ready    <= 1'b1;
        par_err_mask <= '0;
        slot         <= '0;
        if (par_err_mask != '0 && err_count != 8'hFF) err_count <= err_count + 8'd1;
        state        <= RES_WAIT;
      end
    end
  end

  aes_block_serializer #(
    .BLOCK_BYTES(BLOCK_BYTES)
  ) serializer (
    .clock    (clock),
    .reset    (reset),
    .start    (serStart),
    .blockIn  (res_data),
    .done     (serDone),
    .tx_busy  (tx_busy),
    .tx_begin (tx_begin),
    .tx_data  (tx_data),
    .tx_parity(tx_parity)
  );

endmodule
